qsort_seq: RTL and testbench
============================

QSORT_SEQ -- requirements
Module: qsort_seq

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 12, engine AXI-Lite address width.
REQ-002 SHALL have parameter pDATA_WIDTH, default 32, data width of all streams and AXI-Lite data.
REQ-003 SHALL have parameter POLL_GAP, default 4, idle cycles between ap_done status reads.
REQ-004 SHALL have axis_clk  in  1  sole clock; one clock; all logic on rising edge.
REQ-005 SHALL have axis_rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have rq_tvalid  in  2  per-requester input word valid (bit i = requester i).
REQ-007 SHALL have rq_tdata  in  2*pDATA_WIDTH  per-requester input word, requester i in slice i.
REQ-008 SHALL have rq_tready  out  2  per-requester input ready.
REQ-009 SHALL have rs_tvalid / rs_tready / rs_tlast  out/in/out  2 each  per-requester result stream handshake and last flag.
REQ-010 SHALL have rs_tdata  out  pDATA_WIDTH  result word, shared by both requesters.
REQ-011 SHALL have eng_rst_n  out  1  sort-engine reset, active-low.
REQ-012 SHALL have eng_addr  out  pADDR_WIDTH  AXI-Lite address for both aw and ar channels, always 0.
REQ-013 SHALL have eng_awvalid / eng_wvalid / eng_wdata  out  1/1/pDATA_WIDTH  control write to engine.
REQ-014 SHALL have eng_awready / eng_wready  in  1 each  engine write-channel readies.
REQ-015 SHALL have eng_arvalid / eng_rready  out  1 each; eng_arready / eng_rvalid  in  1 each; eng_rdata  in  pDATA_WIDTH  status read.
REQ-016 SHALL have eng_ss_tvalid / eng_ss_tdata  out  1/pDATA_WIDTH; eng_ss_tready  in  1  stream to engine.
REQ-017 SHALL have eng_sm_tvalid / eng_sm_tdata  in  1/pDATA_WIDTH; eng_sm_tready  out  1  stream from engine.
REQ-018 SHALL have seq_err  out  1  one-cycle timeout pulse.

Function
REQ-019 A job SHALL be exactly 11 words in and 11 sorted words out, serving one requester.
REQ-020 FSM states SHALL be IDLE, ERST, START, LOAD, POLL, GAP, DRAIN.
REQ-021 IDLE: on any rq_tvalid, SHALL grant one requester, then go to ERST; with both valid, SHALL grant the requester opposite the last grant (requester 0 first after reset).
REQ-022 ERST: SHALL drive eng_rst_n=0 for exactly one cycle, then go to START.
REQ-023 START: SHALL hold eng_awvalid=eng_wvalid=1 with eng_wdata=1 until both readies are seen (each channel drops independently once handshaken), then go to LOAD.
REQ-024 LOAD: SHALL combinationally forward the granted requester's stream to eng_ss_* (rq_tready[g]=eng_ss_tready) and count 11 handshakes, then go to POLL; the non-granted rq_tready SHALL stay 0.
REQ-025 POLL: SHALL hold eng_arvalid until eng_arready, then hold eng_rready until eng_rvalid; if eng_rdata[1]=1, SHALL go to DRAIN, else to GAP.
REQ-026 GAP: SHALL wait POLL_GAP cycles, then return to POLL.
REQ-027 DRAIN: SHALL forward eng_sm_* to rs_*[g] (eng_sm_tready=rs_tready[g]), assert rs_tlast[g] on the 11th word, then go to IDLE.
REQ-028 A requester that deasserts valid or ready mid-job SHALL stall the FSM with no data lost or duplicated.
REQ-029 rq_tvalid from the non-granted requester during a job SHALL be ignored until IDLE.
REQ-030 Min job latency SHALL be 1 (IDLE) +1 (ERST) +1 (START) +11 (LOAD) +polls +11 (DRAIN) cycles.

Reset
REQ-031 While axis_rst_n=0 at a clock edge: state=IDLE, counters=0, grant pointer=requester 0, eng_rst_n=0, all valid/ready/last outputs=0, seq_err=0, data outputs=0.
REQ-032 Reset mid-job SHALL abandon the job with no rs_tlast emitted; eng_rst_n SHALL return to 1 in IDLE.

Configuration
REQ-033 With QSORT_SEQ_TIMEOUT_EN defined: after 64 consecutive polls reading ap_done=0, SHALL pulse seq_err for one cycle, emit 11 words of 32'hFFFFFFFF to the granted requester (rs_tlast on the 11th), then go to IDLE; without it, SHALL poll indefinitely and tie seq_err to 0.

Verification
REQ-034 Requester 0 sends 5,3,9,1,0,8,2,7,6,4,10 -> rs_tdata[0] 0..10 in order, rs_tlast on 10, one eng_rst_n low pulse before the job.
REQ-035 Both requesters valid in IDLE -> requester 0 served first, then requester 1; rq_tready[1]=0 throughout job 0.
REQ-036 rs_tready[g] toggles 1/0 every cycle during DRAIN -> all 11 words delivered exactly once, in order.
REQ-037 Engine reports ap_done on the 3rd poll -> exactly 3 eng_arvalid handshakes, with POLL_GAP idle cycles between them.
REQ-038 axis_rst_n=0 after the 6th LOAD word -> all outputs at reset values next cycle; next job completes correctly.
REQ-039 With QSORT_SEQ_TIMEOUT_EN defined and engine never done -> seq_err pulse after 64 polls, then 11 words of 32'hFFFFFFFF with rs_tlast.

Source files
------------

// File: rtl/qsort_seq.sv
// qsort_seq: serves two requesters in turn on one sort engine, 11 words per job; define QSORT_SEQ_TIMEOUT_EN to abort a job after 64 not-done polls
module qsort_seq #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int POLL_GAP = 4
) (
  input  logic                     axis_clk,
  input  logic                     axis_rst_n,
  input  logic [1:0]               rq_tvalid,
  input  logic [2*pDATA_WIDTH-1:0] rq_tdata,
  output logic [1:0]               rq_tready,
  output logic [1:0]               rs_tvalid,
  input  logic [1:0]               rs_tready,
  output logic [1:0]               rs_tlast,
  output logic [pDATA_WIDTH-1:0]   rs_tdata,
  output logic                     eng_rst_n,
  output logic [pADDR_WIDTH-1:0]   eng_addr,
  output logic                     eng_awvalid,
  input  logic                     eng_awready,
  output logic                     eng_wvalid,
  input  logic                     eng_wready,
  output logic [pDATA_WIDTH-1:0]   eng_wdata,
  output logic                     eng_arvalid,
  input  logic                     eng_arready,
  input  logic                     eng_rvalid,
  output logic                     eng_rready,
  input  logic [pDATA_WIDTH-1:0]   eng_rdata,
  output logic                     eng_ss_tvalid,
  input  logic                     eng_ss_tready,
  output logic [pDATA_WIDTH-1:0]   eng_ss_tdata,
  input  logic                     eng_sm_tvalid,
  output logic                     eng_sm_tready,
  input  logic [pDATA_WIDTH-1:0]   eng_sm_tdata,
  output logic                     seq_err
);
  localparam logic [3:0] LAST = 4'd10;
  typedef enum logic [2:0] {IDLE, ERST, START, LOAD, POLL, GAP, DRAIN} state_t;
  state_t state;
  logic g, ptr, nxt_g, tout;
  logic [3:0] cnt;
  logic [15:0] gap_cnt;
  logic [pDATA_WIDTH-1:0] rq_sel;
  logic load, drain, rs_v, ss_hs, rs_hs, ar_hs, r_hs, w_ok;
  logic unused_rdata;
  assign eng_addr = '0;
  assign unused_rdata = ^{eng_rdata[pDATA_WIDTH-1:2], eng_rdata[0]};
  assign rq_sel = g ? rq_tdata[2*pDATA_WIDTH-1:pDATA_WIDTH] : rq_tdata[pDATA_WIDTH-1:0];
  // Stream pass-through between the granted requester and the engine
  always_comb begin
    load = state == LOAD;
    drain = state == DRAIN;
    nxt_g = &rq_tvalid ? ptr : rq_tvalid[1];
    eng_ss_tvalid = load && rq_tvalid[g];
    eng_ss_tdata = load ? rq_sel : '0;
    rq_tready = {2{load && eng_ss_tready}} & (g ? 2'b10 : 2'b01);
    eng_sm_tready = drain && !tout && rs_tready[g];
    rs_v = drain && (tout || eng_sm_tvalid);
    rs_tvalid = {2{rs_v}} & (g ? 2'b10 : 2'b01);
    rs_tlast = {2{rs_v && cnt == LAST}} & (g ? 2'b10 : 2'b01);
    rs_tdata = drain ? (tout ? '1 : eng_sm_tdata) : '0;
    ss_hs = eng_ss_tvalid && eng_ss_tready;
    rs_hs = rs_v && rs_tready[g];
    ar_hs = eng_arvalid && eng_arready;
    r_hs = eng_rready && eng_rvalid;
    w_ok = (!eng_awvalid || eng_awready) && (!eng_wvalid || eng_wready);
  end
`ifdef QSORT_SEQ_TIMEOUT_EN
  logic [5:0] poll_cnt;
`else
  assign tout = 1'b0;
  assign seq_err = 1'b0;
`endif
  // Job sequencer: grant, engine reset, start, load, poll, drain
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state <= IDLE;
      g <= 1'b0;
      ptr <= 1'b0;
      cnt <= '0;
      gap_cnt <= '0;
      eng_rst_n <= 1'b0;
      eng_awvalid <= 1'b0;
      eng_wvalid <= 1'b0;
      eng_wdata <= '0;
      eng_arvalid <= 1'b0;
      eng_rready <= 1'b0;
`ifdef QSORT_SEQ_TIMEOUT_EN
      poll_cnt <= '0;
      tout <= 1'b0;
      seq_err <= 1'b0;
`endif
    end else begin
`ifdef QSORT_SEQ_TIMEOUT_EN
      seq_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          eng_rst_n <= ~|rq_tvalid;
          if (|rq_tvalid) begin
            g <= nxt_g;
            ptr <= ~nxt_g;
            state <= ERST;
          end
        end
        ERST: begin
          eng_rst_n <= 1'b1;
          eng_awvalid <= 1'b1;
          eng_wvalid <= 1'b1;
          eng_wdata <= pDATA_WIDTH'(1);
          cnt <= '0;
`ifdef QSORT_SEQ_TIMEOUT_EN
          poll_cnt <= '0;
          tout <= 1'b0;
`endif
          state <= START;
        end
        START: begin
          eng_awvalid <= eng_awvalid && !eng_awready;
          eng_wvalid <= eng_wvalid && !eng_wready;
          if (w_ok) begin
            eng_wdata <= '0;
            state <= LOAD;
          end
        end
        LOAD: if (ss_hs) begin
          cnt <= cnt == LAST ? '0 : cnt + 4'd1;
          if (cnt == LAST) begin
            eng_arvalid <= 1'b1;
            state <= POLL;
          end
        end
        POLL: begin
          if (ar_hs) begin
            eng_arvalid <= 1'b0;
            eng_rready <= 1'b1;
          end
          if (r_hs) begin
            eng_rready <= 1'b0;
            gap_cnt <= '0;
            if (eng_rdata[1]) state <= DRAIN;
`ifdef QSORT_SEQ_TIMEOUT_EN
            else if (&poll_cnt) begin
              seq_err <= 1'b1;
              tout <= 1'b1;
              state <= DRAIN;
            end else begin
              poll_cnt <= poll_cnt + 6'd1;
              state <= GAP;
            end
`else
            else state <= GAP;
`endif
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 16'd1;
          if (int'(gap_cnt) >= POLL_GAP - 1) begin
            eng_arvalid <= 1'b1;
            state <= POLL;
          end
        end
        DRAIN: if (rs_hs) begin
          cnt <= cnt == LAST ? '0 : cnt + 4'd1;
          if (cnt == LAST) begin
`ifdef QSORT_SEQ_TIMEOUT_EN
            tout <= 1'b0;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qsort_seq.sv
// tb_qsort_seq: randomized bench for qsort_seq with a behavioural engine and a sorted-output reference
module tb_qsort_seq;
  localparam int AW = 12, DW = 32, PG = 4, N = 11;
  typedef logic [DW-1:0] wq_t[$];
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] rq_tvalid, rq_tready, rs_tvalid, rs_tready, rs_tlast;
  logic [2*DW-1:0] rq_tdata;
  logic [DW-1:0] rs_tdata, eng_wdata, eng_rdata, eng_ss_tdata, eng_sm_tdata;
  logic [AW-1:0] eng_addr;
  logic eng_rst_n, eng_awvalid, eng_awready, eng_wvalid, eng_wready, eng_arvalid, eng_arready;
  logic eng_rvalid, eng_rready, eng_ss_tvalid, eng_ss_tready, eng_sm_tvalid, eng_sm_tready, seq_err;
  int checks = 0, errors = 0;
  logic [DW-1:0] rq_q[2][$];
  logic [DW-1:0] out_q[2][$];
  logic last_q[2][$];
  logic [DW-1:0] ebuf[$], sm_q[$];
  int rs_mode[2];
  bit rq_rand, eng_rand, tgl, r_pend, in_gap, prev_ern;
  int done_after, polls, ar_cnt, rst_falls, rst_low, err_high, cyc, first_r1, last0_cyc, gap_len;
  int gaps[$];
  logic [1:0] h_rq, h_rs, l_rs;
  logic h_ss, h_ar, h_r, r_done, h_sm;
  logic [DW-1:0] d_ss, d_rs;

  always #5 clk = ~clk;

  qsort_seq #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .POLL_GAP(PG)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .rq_tvalid(rq_tvalid), .rq_tdata(rq_tdata), .rq_tready(rq_tready),
    .rs_tvalid(rs_tvalid), .rs_tready(rs_tready), .rs_tlast(rs_tlast), .rs_tdata(rs_tdata),
    .eng_rst_n(eng_rst_n), .eng_addr(eng_addr),
    .eng_awvalid(eng_awvalid), .eng_awready(eng_awready),
    .eng_wvalid(eng_wvalid), .eng_wready(eng_wready), .eng_wdata(eng_wdata),
    .eng_arvalid(eng_arvalid), .eng_arready(eng_arready),
    .eng_rvalid(eng_rvalid), .eng_rready(eng_rready), .eng_rdata(eng_rdata),
    .eng_ss_tvalid(eng_ss_tvalid), .eng_ss_tready(eng_ss_tready), .eng_ss_tdata(eng_ss_tdata),
    .eng_sm_tvalid(eng_sm_tvalid), .eng_sm_tready(eng_sm_tready), .eng_sm_tdata(eng_sm_tdata),
    .seq_err(seq_err)
  );

  function automatic wq_t sorted(input wq_t q);
    wq_t r = q;
    r.sort();
    return r;
  endfunction

  // Requesters, result sinks and a behavioural sort engine; handshakes sampled mid-cycle, committed at the next negedge
  initial begin
    rq_tvalid = '0; rq_tdata = '0; rs_tready = '0;
    eng_awready = 0; eng_wready = 0; eng_arready = 0; eng_rvalid = 0; eng_rdata = '0;
    eng_ss_tready = 0; eng_sm_tvalid = 0; eng_sm_tdata = '0;
    h_rq = '0; h_rs = '0; l_rs = '0; h_ss = 0; h_ar = 0; h_r = 0; r_done = 0; h_sm = 0;
    d_ss = '0; d_rs = '0; prev_ern = 1'b1;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (h_rq[i] && rq_q[i].size() > 0) rq_q[i].delete(0);
        if (h_rs[i]) begin out_q[i].push_back(d_rs); last_q[i].push_back(l_rs[i]); end
      end
      if (h_ss) ebuf.push_back(d_ss);
      if (h_ar) begin polls++; ar_cnt++; r_pend = 1; end
      if (h_r) begin
        r_pend = 0;
        if (r_done) sm_q = sorted(ebuf);
        else begin in_gap = 1; gap_len = 0; end
      end
      if (h_sm && sm_q.size() > 0) sm_q.delete(0);
      if (!eng_rst_n) begin ebuf.delete(); sm_q.delete(); polls = 0; r_pend = 0; end
      tgl = ~tgl;
      for (int i = 0; i < 2; i++) begin
        rq_tvalid[i] = rq_q[i].size() > 0 && (!rq_rand || $urandom_range(0, 3) != 0);
        rq_tdata[i*DW +: DW] = rq_q[i].size() > 0 ? rq_q[i][0] : '0;
        rs_tready[i] = rs_mode[i] == 0 ? 1'b1 : rs_mode[i] == 1 ? tgl : 1'($urandom_range(0, 1));
      end
      eng_ss_tready = !eng_rand || $urandom_range(0, 2) != 0;
      eng_awready = !eng_rand || $urandom_range(0, 1) != 0;
      eng_wready = !eng_rand || $urandom_range(0, 1) != 0;
      eng_arready = !eng_rand || $urandom_range(0, 1) != 0;
      eng_rvalid = r_pend;
      eng_rdata = ($urandom() & ~32'd2) | ((done_after > 0 && polls >= done_after) ? 32'd2 : 32'd0);
      eng_sm_tvalid = sm_q.size() > 0 && (!eng_rand || $urandom_range(0, 2) != 0);
      eng_sm_tdata = sm_q.size() > 0 ? sm_q[0] : '0;
      cyc++;
      #1;
      h_rq = rq_tvalid & rq_tready; h_rs = rs_tvalid & rs_tready; l_rs = rs_tlast; d_rs = rs_tdata;
      h_ss = eng_ss_tvalid && eng_ss_tready; d_ss = eng_ss_tdata;
      h_ar = eng_arvalid && eng_arready; h_r = eng_rready && eng_rvalid; r_done = eng_rdata[1];
      h_sm = eng_sm_tvalid && eng_sm_tready;
      if (in_gap) begin
        if (!eng_arvalid && !eng_rready) gap_len++;
        else begin gaps.push_back(gap_len); in_gap = 0; end
      end
      if (seq_err) err_high++;
      if (!eng_rst_n) rst_low++;
      if (!eng_rst_n && prev_ern) rst_falls++;
      prev_ern = eng_rst_n;
      if (rq_tready[1] && first_r1 < 0) first_r1 = cyc;
      if (h_rs[0] && rs_tlast[0]) last0_cyc = cyc;
    end
  end

  task automatic wait_out(input int r, input int n, input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #2;
      if (out_q[r].size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic clear_outs();
    for (int i = 0; i < 2; i++) begin out_q[i].delete(); last_q[i].delete(); end
  endtask

  task automatic test_reset();
    rs_mode = '{0, 0}; rq_rand = 0; eng_rand = 0; done_after = 1;
    rst_n = 0;
    repeat (3) @(negedge clk);
    #2;
    checks++; if ({rq_tready, rs_tvalid, rs_tlast} !== 6'b0) begin errors++; $display("FAIL reset_stream_ctl got %b exp 0", {rq_tready, rs_tvalid, rs_tlast}); end
    checks++; if ({eng_rst_n, eng_awvalid, eng_wvalid, eng_arvalid, eng_rready, eng_ss_tvalid, eng_sm_tready, seq_err} !== 8'b0) begin errors++; $display("FAIL reset_eng_ctl got %b exp 0", {eng_rst_n, eng_awvalid, eng_wvalid, eng_arvalid, eng_rready, eng_ss_tvalid, eng_sm_tready, seq_err}); end
    checks++; if ({rs_tdata, eng_wdata, eng_ss_tdata, eng_addr} !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", {rs_tdata, eng_wdata, eng_ss_tdata, eng_addr}); end
    rst_n = 1;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (eng_rst_n !== 1'b1) begin errors++; $display("FAIL idle_eng_rst_n got %b exp 1", eng_rst_n); end
  endtask

  task automatic test_arbitration();
    wq_t a, b, ea, eb;
    bit ok;
    clear_outs();
    for (int k = 0; k < N; k++) begin a.push_back($urandom()); b.push_back($urandom()); end
    ea = sorted(a); eb = sorted(b);
    first_r1 = -1; last0_cyc = -1;
    rq_q[0] = a; rq_q[1] = b;
    wait_out(1, N, 3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL arb_timeout got %0d words exp %0d", out_q[1].size(), N); end
    for (int k = 0; k < N; k++) begin
      checks++; if (out_q[0][k] !== ea[k]) begin errors++; $display("FAIL arb_r0_word%0d got %h exp %h", k, out_q[0][k], ea[k]); end
      checks++; if (out_q[1][k] !== eb[k]) begin errors++; $display("FAIL arb_r1_word%0d got %h exp %h", k, out_q[1][k], eb[k]); end
    end
    checks++; if (!(last0_cyc >= 0 && first_r1 > last0_cyc)) begin errors++; $display("FAIL arb_order r1_ready_cycle %0d r0_last_cycle %0d exp later", first_r1, last0_cyc); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] v[N] = '{5, 3, 9, 1, 0, 8, 2, 7, 6, 4, 10};
    bit ok;
    clear_outs();
    repeat (2) @(negedge clk);
    rst_falls = 0; rst_low = 0;
    for (int k = 0; k < N; k++) rq_q[0].push_back(v[k]);
    wait_out(0, N, 3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got %0d words exp %0d", out_q[0].size(), N); end
    for (int k = 0; k < N; k++) begin
      checks++; if (out_q[0][k] !== DW'(k)) begin errors++; $display("FAIL basic_word%0d got %h exp %h", k, out_q[0][k], k); end
      checks++; if (last_q[0][k] !== (k == N - 1)) begin errors++; $display("FAIL basic_last%0d got %b exp %b", k, last_q[0][k], k == N - 1); end
    end
    checks++; if (rst_falls != 1 || rst_low != 1) begin errors++; $display("FAIL basic_eng_rst pulses %0d low_cycles %0d exp 1 1", rst_falls, rst_low); end
  endtask

  task automatic test_backpressure();
    wq_t a, e;
    bit ok;
    clear_outs();
    rs_mode = '{1, 0}; rq_rand = 1;
    for (int k = 0; k < N; k++) a.push_back(DW'($urandom_range(0, 40)));
    e = sorted(a);
    rq_q[0] = a;
    wait_out(0, N, 3000, ok);
    repeat (20) @(negedge clk);
    #2;
    checks++; if (out_q[0].size() != N) begin errors++; $display("FAIL bp_count got %0d exp %0d", out_q[0].size(), N); end
    for (int k = 0; k < N; k++) begin
      checks++; if (out_q[0][k] !== e[k] || last_q[0][k] !== (k == N - 1)) begin errors++; $display("FAIL bp_word%0d got %h/%b exp %h/%b", k, out_q[0][k], last_q[0][k], e[k], k == N - 1); end
    end
    rs_mode = '{0, 0}; rq_rand = 0;
  endtask

  task automatic test_poll();
    wq_t a, e;
    bit ok;
    clear_outs();
    done_after = 3; ar_cnt = 0; gaps.delete();
    for (int k = 0; k < N; k++) a.push_back($urandom());
    e = sorted(a);
    rq_q[1] = a;
    wait_out(1, N, 3000, ok);
    checks++; if (ar_cnt != 3) begin errors++; $display("FAIL poll_count got %0d exp 3", ar_cnt); end
    checks++; if (gaps.size() != 2) begin errors++; $display("FAIL poll_gap_count got %0d exp 2", gaps.size()); end
    for (int k = 0; k < gaps.size(); k++) begin
      checks++; if (gaps[k] != PG) begin errors++; $display("FAIL poll_gap%0d got %0d exp %0d", k, gaps[k], PG); end
    end
    for (int k = 0; k < N; k++) begin
      checks++; if (out_q[1][k] !== e[k]) begin errors++; $display("FAIL poll_word%0d got %h exp %h", k, out_q[1][k], e[k]); end
    end
    done_after = 1;
  endtask

  task automatic test_midreset();
    wq_t a, e;
    bit ok;
    clear_outs();
    for (int k = 0; k < N; k++) a.push_back($urandom());
    rq_q[0] = a;
    ok = 0;
    for (int k = 0; k < 500 && !ok; k++) begin @(negedge clk); #2; ok = ebuf.size() >= 6; end
    checks++; if (!ok) begin errors++; $display("FAIL midrst_load got %0d words exp 6", ebuf.size()); end
    rst_n = 0;
    @(negedge clk); #2;
    checks++; if ({rq_tready, rs_tvalid, rs_tlast, eng_rst_n, eng_awvalid, eng_wvalid, eng_arvalid, eng_rready, eng_ss_tvalid, eng_sm_tready, seq_err} !== 14'b0) begin errors++; $display("FAIL midrst_ctl got %b exp 0", {rq_tready, rs_tvalid, rs_tlast, eng_rst_n, eng_awvalid, eng_wvalid, eng_arvalid, eng_rready, eng_ss_tvalid, eng_sm_tready, seq_err}); end
    checks++; if ({rs_tdata, eng_wdata, eng_ss_tdata} !== '0) begin errors++; $display("FAIL midrst_data got %h exp 0", {rs_tdata, eng_wdata, eng_ss_tdata}); end
    rq_q[0].delete();
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk); #2;
    checks++; if (out_q[0].size() != 0) begin errors++; $display("FAIL midrst_no_output got %0d words exp 0", out_q[0].size()); end
    checks++; if (eng_rst_n !== 1'b1) begin errors++; $display("FAIL midrst_eng_rst_n got %b exp 1", eng_rst_n); end
    a.delete();
    for (int k = 0; k < N; k++) a.push_back($urandom());
    e = sorted(a);
    rq_q[0] = a;
    wait_out(0, N, 3000, ok);
    for (int k = 0; k < N; k++) begin
      checks++; if (out_q[0][k] !== e[k] || last_q[0][k] !== (k == N - 1)) begin errors++; $display("FAIL midrst_word%0d got %h/%b exp %h/%b", k, out_q[0][k], last_q[0][k], e[k], k == N - 1); end
    end
  endtask

`ifdef QSORT_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    clear_outs();
    done_after = 0; ar_cnt = 0; err_high = 0;
    for (int k = 0; k < N; k++) rq_q[1].push_back($urandom());
    wait_out(1, N, 4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tout_timeout got %0d words exp %0d", out_q[1].size(), N); end
    checks++; if (err_high != 1) begin errors++; $display("FAIL tout_seq_err cycles got %0d exp 1", err_high); end
    checks++; if (ar_cnt != 64) begin errors++; $display("FAIL tout_polls got %0d exp 64", ar_cnt); end
    for (int k = 0; k < N; k++) begin
      checks++; if (out_q[1][k] !== 32'hFFFFFFFF || last_q[1][k] !== (k == N - 1)) begin errors++; $display("FAIL tout_word%0d got %h/%b exp ffffffff/%b", k, out_q[1][k], last_q[1][k], k == N - 1); end
    end
    done_after = 1;
  endtask
`else
  task automatic test_no_timeout();
    clear_outs();
    done_after = 0; ar_cnt = 0; err_high = 0;
    for (int k = 0; k < N; k++) rq_q[1].push_back($urandom());
    repeat (1000) @(negedge clk);
    #2;
    checks++; if (err_high != 0) begin errors++; $display("FAIL notout_seq_err got %0d exp 0", err_high); end
    checks++; if (ar_cnt <= 64 || out_q[1].size() != 0) begin errors++; $display("FAIL notout_polling polls %0d words %0d exp >64 and 0", ar_cnt, out_q[1].size()); end
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    rq_q[1].delete();
    done_after = 1;
    repeat (2) @(negedge clk);
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [1:0] who = 2'($urandom_range(1, 3));
      wq_t exp_q[2];
      bit ok;
      clear_outs();
      rs_mode = '{$urandom_range(0, 2), $urandom_range(0, 2)};
      rq_rand = 1; eng_rand = 1; done_after = $urandom_range(1, 3);
      for (int i = 0; i < 2; i++) if (who[i]) begin
        for (int k = 0; k < N; k++) exp_q[i].push_back(it[0] ? DW'($urandom_range(0, 7)) : $urandom());
        rq_q[i] = exp_q[i];
        exp_q[i] = sorted(exp_q[i]);
      end
      for (int i = 0; i < 2; i++) if (who[i]) begin
        wait_out(i, N, 4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rand%0d_r%0d_timeout got %0d words exp %0d", it, i, out_q[i].size(), N); end
        for (int k = 0; k < N; k++) begin
          checks++; if (out_q[i][k] !== exp_q[i][k] || last_q[i][k] !== (k == N - 1)) begin errors++; $display("FAIL rand%0d_r%0d_word%0d got %h/%b exp %h/%b", it, i, k, out_q[i][k], last_q[i][k], exp_q[i][k], k == N - 1); end
        end
      end
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_basic();
    test_backpressure();
    test_poll();
    test_midreset();
`ifdef QSORT_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
